// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-bit multiply/divide unit with HI/LO registers
// Optional divide datapath (ops DIVU/DIV and dbz flag) is enabled by defining MDU_DIV_EN.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    count;
  logic             op_ok;
  logic             accept;
  logic             last_iter;

  // Operand magnitudes (signed ops work on magnitudes, sign fixed up in FIX)
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  // Iteration registers: p_hi/p_lo are the product accumulator or remainder/quotient
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;
  logic             neg_res;

  // One shift-add multiply step
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  // Sign-corrected 64-bit product
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;

`ifdef MDU_DIV_EN
  logic             is_div;
  logic             neg_rem;
  logic             dbz_q;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             div_zero;
`endif

`ifdef MDU_DIV_EN
  assign op_ok = 1'b1;
`else
  assign op_ok = ~op[1];
`endif

  assign accept    = (state == S_IDLE) && start && op_ok;
  assign last_iter = (count == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and busy: IDLE -> RUN (32 steps) -> FIX (sign fix, writeback) -> IDLE
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (accept) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (last_iter) begin
          state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        busy      = 1'b0;
      end
    endcase
  end

  // Operand magnitudes; only op[0] (signed) takes the absolute value
  always_comb begin
    mag_a = src_a;
    mag_b = src_b;
    if (op[0] && src_a[WIDTH-1]) begin
      mag_a = -src_a;
    end
    if (op[0] && src_b[WIDTH-1]) begin
      mag_b = -src_b;
    end
  end

  // Shift-add multiply step and final product sign correction
  always_comb begin
    add_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    mul_hi   = add_sum[WIDTH:1];
    mul_lo   = {add_sum[0], p_lo[WIDTH-1:1]};
    prod_raw = {p_hi, p_lo};
    prod_fix = neg_res ? ((2*WIDTH)'(0) - prod_raw) : prod_raw;
  end

`ifdef MDU_DIV_EN
  // Restoring divide step: shift in next dividend bit, subtract if it fits.
  // A zero divisor always "fits", leaving all-ones quotient and remainder = |dividend|.
  always_comb begin
    trial    = {p_hi, p_lo[WIDTH-1]} - {1'b0, mcand};
    div_hi   = trial[WIDTH] ? {p_hi[WIDTH-2:0], p_lo[WIDTH-1]} : trial[WIDTH-1:0];
    div_lo   = {p_lo[WIDTH-2:0], ~trial[WIDTH]};
    div_zero = (mcand == '0);
    quo_fix  = neg_res ? -p_lo : p_lo;
    rem_fix  = neg_rem ? -p_hi : p_hi;
    if (div_zero) begin
      quo_fix = '1;
    end
  end

  assign dbz = dbz_q;
`else
  assign dbz = 1'b0;
`endif

  // Datapath: operand latch, iteration, writeback and MTHI/MTLO
  always_ff @(posedge clk) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      count   <= '0;
      mcand   <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      neg_res <= 1'b0;
`ifdef MDU_DIV_EN
      is_div  <= 1'b0;
      neg_rem <= 1'b0;
      dbz_q   <= 1'b0;
`endif
    end else begin
      done <= (state == S_FIX);
      case (state)
        S_IDLE: begin
          if (accept) begin
            count   <= '0;
            mcand   <= mag_b;
            p_hi    <= '0;
            p_lo    <= mag_a;
            neg_res <= op[0] & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
`ifdef MDU_DIV_EN
            is_div  <= op[1];
            neg_rem <= op[0] & src_a[WIDTH-1];
`endif
          end else if (!start) begin
            if (hi_we) begin
              hi <= src_a;
            end
            if (lo_we) begin
              lo <= src_a;
            end
          end
        end
        S_RUN: begin
          count <= count + CW'(1);
`ifdef MDU_DIV_EN
          if (is_div) begin
            p_hi <= div_hi;
            p_lo <= div_lo;
          end else begin
            p_hi <= mul_hi;
            p_lo <= mul_lo;
          end
`else
          p_hi <= mul_hi;
          p_lo <= mul_lo;
`endif
        end
        S_FIX: begin
`ifdef MDU_DIV_EN
          if (is_div) begin
            hi    <= rem_fix;
            lo    <= quo_fix;
            dbz_q <= div_zero;
          end else begin
            hi    <= prod_fix[2*WIDTH-1:WIDTH];
            lo    <= prod_fix[WIDTH-1:0];
            dbz_q <= 1'b0;
          end
`else
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
`endif
        end
        default: begin
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - table-driven bench for mult_div_unit (divide vectors when MDU_DIV_EN is defined)
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hi_we;
  logic        lo_we;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;
  } vec_t;

  vec_t vecs[$];

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one operation; inj>0 pokes start+hi_we+lo_we at that cycle while busy
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int inj, output int lat, output int bcnt);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    lat   = 0;
    bcnt  = 0;
    while (lat < 60) begin
      tick();
      lat++;
      if (lat == 1) start = 1'b0;
      if (inj != 0 && lat == inj) begin
        start = 1'b1; op = 2'b00; src_a = 32'hDEAD_BEEF; src_b = 32'h7;
        hi_we = 1'b1; lo_we = 1'b1;
      end
      if (inj != 0 && lat == inj + 1) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      if (busy) bcnt++;
      if (done) break;
    end
  endtask

  initial begin
    int lat;
    int bcnt;
    bit saw_done;
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;

    vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
    vecs.push_back('{2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0});
    vecs.push_back('{2'b00, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 1'b0});
    vecs.push_back('{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0});
    vecs.push_back('{2'b01, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0});
    vecs.push_back('{2'b00, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0});
`ifdef MDU_DIV_EN
    vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{2'b10, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{2'b00, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b0});
    vecs.push_back('{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0});
    vecs.push_back('{2'b10, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0});
    vecs.push_back('{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0});
`endif

    reset = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; hi_we = 1'b0; lo_we = 1'b0;
    tick(); tick(); tick();
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_done", 64'(done), 64'h0);
    check("reset_dbz", 64'(dbz), 64'h0);
    reset = 1'b0;

    // Back-to-back vectors: each start lands in the previous done cycle
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, lat, bcnt);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'd34);
      check($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'd33);
      check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
      check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
      check($sformatf("v%0d_dbz", i), 64'(dbz), 64'(vecs[i].exp_dbz));
    end

    tick();
    check("done_one_cycle", 64'(done), 64'h0);
    check("idle_after_done", 64'(busy), 64'h0);

    src_a = 32'h1234_5678; hi_we = 1'b1;
    tick();
    hi_we = 1'b0;
    check("mthi_hi", 64'(hi), 64'h1234_5678);
    check("mthi_no_done", 64'(done), 64'h0);
    src_a = 32'hCAFE_F00D; lo_we = 1'b1;
    tick();
    lo_we = 1'b0;
    check("mtlo_lo", 64'(lo), 64'hCAFE_F00D);

    // Second start plus MTHI/MTLO at cycle 10 of a busy multiply must be ignored
    do_op(2'b00, 32'h2, 32'h3, 10, lat, bcnt);
    check("busy_ign_latency", 64'(lat), 64'd34);
    check("busy_ign_lo", 64'(lo), 64'h6);
    check("busy_ign_hi", 64'(hi), 64'h0);
    tick();
    check("busy_ign_no_queue", 64'(busy), 64'h0);

    // Reset at cycle 20 of an operation aborts it
`ifdef MDU_DIV_EN
    op = 2'b10;
`else
    op = 2'b00;
`endif
    src_a = 32'h64; src_b = 32'h7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_done", 64'(done), 64'h0);
    check("abort_hi", 64'(hi), 64'h0);
    check("abort_lo", 64'(lo), 64'h0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 64'(saw_done), 64'h0);
    do_op(2'b00, 32'h2, 32'h3, 0, lat, bcnt);
    check("after_abort_latency", 64'(lat), 64'd34);
    check("after_abort_lo", 64'(lo), 64'h6);

`ifndef MDU_DIV_EN
    // Divide ops are rejected in the multiply-only build
    hold_hi = hi;
    hold_lo = lo;
    op = 2'b10; src_a = 32'h64; src_b = 32'h0; start = 1'b1;
    tick();
    start = 1'b0;
    check("nodiv_busy", 64'(busy), 64'h0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    check("nodiv_no_activity", 64'(saw_done), 64'h0);
    check("nodiv_hi", 64'(hi), 64'(hold_hi));
    check("nodiv_lo", 64'(lo), 64'(hold_lo));
    check("nodiv_dbz", 64'(dbz), 64'h0);
`else
    hold_hi = 32'h0;
    hold_lo = 32'h0;
    check("div_hold_unused", 64'(hold_hi | hold_lo | {31'h0, dbz}), 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
